// File: rtl/debounce_pkg.sv
// Shared types and constants for the switch debouncer.
// The helper sizes counters so that a terminal count of zero still gets a 1-bit register.
package debounce_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } db_state_t;

    localparam int TB_TICK_DIV     = 4;
    localparam int TB_STABLE_TICKS = 3;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both flops clear to 0 on the asynchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_q;

    // NOTE: non-blocking assignments make both flops sample their old values on the
    // same edge; blocking here would collapse the chain into a single flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/switch_debounce_fsm.sv
// Debounces a raw switch: the synchronized level must hold for STABLE_TICKS ticks of
// TICK_DIV clocks before db follows it. db and busy are decoded from the state register only.
module switch_debounce_fsm
    import debounce_pkg::*;
#(
    parameter int TICK_DIV     = 100_000,
    parameter int STABLE_TICKS = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db,
    output logic busy
);

    localparam int DIV_W = cnt_width(TICK_DIV);
    localparam int CNT_W = cnt_width(STABLE_TICKS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic             w_sw_s;
    logic             w_tick;
    db_state_t        r_state;
    db_state_t        w_state_nxt;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] w_div_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sw),
        .q     (w_sw_s)
    );

    assign w_tick = (r_div == DIV_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ZERO;
            r_div   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ZERO: begin
                if (w_sw_s) begin
                    w_state_nxt = WAIT1;
                    w_div_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT1: begin
                if (!w_sw_s) begin
                    w_state_nxt = ZERO;
                    w_div_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else if (w_tick) begin
                    w_div_nxt = '0;
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ONE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end
            ONE: begin
                if (!w_sw_s) begin
                    w_state_nxt = WAIT0;
                    w_div_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            end
            WAIT0: begin
                if (w_sw_s) begin
                    w_state_nxt = ONE;
                    w_div_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else if (w_tick) begin
                    w_div_nxt = '0;
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ZERO;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ZERO;
                w_div_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign db   = (r_state == ONE)   || (r_state == WAIT0);
    assign busy = (r_state == WAIT1) || (r_state == WAIT0);

endmodule

// File: tb/tb_switch_debounce_fsm.sv
// Bench for switch_debounce_fsm: a vector table, hand-written corner sequences, and random
// switch activity compared against a run-length model of the debounce rule.
module tb_switch_debounce_fsm;
    import debounce_pkg::*;

    localparam int QUAL = TB_TICK_DIV * TB_STABLE_TICKS;

    logic clk;
    logic reset;
    logic sw;
    logic db;
    logic busy;

    switch_debounce_fsm #(
        .TICK_DIV     (TB_TICK_DIV),
        .STABLE_TICKS (TB_STABLE_TICKS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw),
        .db    (db),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: db flips once the synchronized input has disagreed with it on QUAL+1
    // consecutive edges; busy means a disagreement run is in progress.
    logic m_q[$];
    int   m_run;
    logic m_db;

    typedef struct {
        logic sw;
        logic db;
        logic busy;
    } vec_t;

    vec_t vecs[40];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q   = '{1'b0, 1'b0};
        m_run = 0;
        m_db  = 1'b0;
    endtask

    task automatic model_edge(input logic v);
        logic s;
        s = m_q.pop_front();
        m_q.push_back(v);
        if (s != m_db) m_run++;
        else m_run = 0;
        if (m_run == QUAL + 1) begin
            m_db  = ~m_db;
            m_run = 0;
        end
    endtask

    task automatic step(input logic v);
        @(negedge clk);
        #2 sw = v;
        @(posedge clk);
        model_edge(v);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   rises;
        int   busy_seen;
        int   steps;
        int   len;
        logic prev_db;
        logic v;

        for (int i = 0; i < 20; i++) vecs[i] = '{1'b0, 1'b0, 1'b0};
        for (int k = 1; k <= 20; k++)
            vecs[19 + k] = '{1'b1, logic'(k >= 15), logic'(k >= 3 && k <= 14)};

        reset = 1'b0;
        sw    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset db", db, 0);
        check("reset busy", busy, 0);
        #2 reset = 1'b1;
        model_reset();

        // Idle low, then a clean rise held
        rises   = 0;
        prev_db = db;
        for (int i = 0; i < 40; i++) begin
            step(vecs[i].sw);
            check($sformatf("vec%0d db", i), db, vecs[i].db);
            check($sformatf("vec%0d busy", i), busy, vecs[i].busy);
            if (db && !prev_db) rises++;
            prev_db = db;
        end
        check("single db rise", rises, 1);

        // Bounce during WAIT1 restarts qualification
        reset = 1'b0;
        #1 reset = 1'b1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            check("bounce db hi", db, 0);
        end
        step(1'b0);
        check("bounce db lo", db, 0);
        for (int k = 1; k <= 15; k++) begin
            step(1'b1);
            check($sformatf("bounce rise k%0d", k), db, logic'(k >= 15));
        end
        repeat (3) step(1'b1);

        // Release, re-press, then a glitch inside WAIT0
        for (int k = 1; k <= 15; k++) begin
            step(1'b0);
            check($sformatf("release k%0d", k), db, logic'(k < 15));
        end
        for (int k = 1; k <= 15; k++) begin
            step(1'b1);
            check($sformatf("repress k%0d", k), db, logic'(k >= 15));
        end
        repeat (4) step(1'b0);
        check("glitch busy", busy, 1);
        check("glitch db", db, 1);
        for (int k = 1; k <= 20; k++) begin
            step(1'b1);
            check($sformatf("glitch hold k%0d", k), db, 1);
        end
        check("glitch back to ONE", busy, 0);

        // Async reset mid-WAIT1
        for (int k = 1; k <= 16; k++) step(1'b0);
        check("pre-reset db", db, 0);
        repeat (6) step(1'b1);
        check("mid WAIT1 busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("async reset busy", busy, 0);
        check("async reset db", db, 0);
        @(posedge clk);
        #3 reset = 1'b1;
        model_reset();
        for (int k = 1; k <= 15; k++) begin
            step(1'b1);
            check($sformatf("post-reset k%0d", k), db, logic'(k >= 15));
        end

        // Single-cycle pulse never qualifies
        for (int k = 1; k <= 16; k++) step(1'b0);
        busy_seen = 0;
        step(1'b1);
        if (busy) busy_seen++;
        check("pulse db", db, 0);
        for (int k = 1; k <= 20; k++) begin
            step(1'b0);
            if (busy) busy_seen++;
            check($sformatf("pulse db k%0d", k), db, 0);
        end
        check("pulse busy cycles<=1", logic'(busy_seen <= 1), 1);

        // Random bursts against the model
        steps = 0;
        while (steps < 1500) begin
            v   = logic'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 20) : $urandom_range(1, 4);
            for (int j = 0; j < len; j++) begin
                step(v);
                check("rand db", db, m_db);
                check("rand busy", busy, logic'(m_run > 0));
                steps++;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
